scv_rominit_loader: RTL and testbench
=====================================

SCV_ROMINIT_LOADER -- requirements
Module: scv_rominit_loader

Interface
REQ-001 CLK  in  1  system clock (clk_sys); all logic is on the rising edge.
REQ-002 RESB  in  1  asynchronous active-low reset.
REQ-003 IOCTL_DOWNLOAD / IOCTL_WR  in  1 / 1  download-active flag / byte strobe from hps_io.
REQ-004 IOCTL_INDEX / IOCTL_ADDR / IOCTL_DOUT  in  8 / 25 / 8  file index / byte address / byte data.
REQ-005 IOCTL_WAIT  out  1  backpressure to hps_io; tied 0.
REQ-006 ROMINIT_SEL_BOOT / ROMINIT_SEL_CHR  out  1 / 1  target is boot ROM / character ROM.
REQ-007 ROMINIT_ADDR / ROMINIT_DATA / ROMINIT_VALID  out  12 / 8 / 1  ROM write address / data / one-cycle write strobe to scv.
REQ-008 CORE_RESB  out  1  active-low reset for the scv core.
REQ-009 BOOT_LOADED / CHR_LOADED / LOAD_ERR  out  1 / 1 / 1  region fully written / region fully written / last download incomplete.

Function
REQ-010 Accepted byte: IOCTL_DOWNLOAD=1, IOCTL_WR=1 and IOCTL_INDEX=0 in the same cycle. All other IOCTL_WR pulses are ignored.
REQ-011 Decode: addr < 0x1000 selects boot, ROMINIT_ADDR = addr[11:0]. 0x1000 <= addr < 0x1400 selects chr, ROMINIT_ADDR = {2'b0, addr[9:0]}. addr >= 0x1400 is discarded with no strobe.
REQ-012 Latency: ROMINIT_* is registered and ROMINIT_VALID pulses for exactly one cycle, one cycle after an accepted in-range byte. SEL, ADDR and DATA hold their values until the next strobe.
REQ-013 Back-to-back accepted bytes on consecutive cycles produce consecutive strobes with no loss.
REQ-014 States: IDLE, LOAD, HOLD, RUN.
  - Transitions: any state -> LOAD when IOCTL_DOWNLOAD rises and IOCTL_INDEX=0; LOAD -> HOLD when IOCTL_DOWNLOAD falls; HOLD -> RUN after HOLD_CYCLES=16 cycles; IDLE is unused after reset.
REQ-015 CORE_RESB is 0 in LOAD and HOLD and 1 only in RUN. It is registered, with no glitches.
REQ-016 Entering LOAD clears both region byte counters, BOOT_LOADED, CHR_LOADED and LOAD_ERR.
REQ-017 Each region counter increments per strobed byte and saturates at the region size (4096 boot, 1024 chr). LOADED is set when the counter reaches its size.
REQ-018 On the LOAD -> HOLD transition, LOAD_ERR = ~(BOOT_LOADED & CHR_LOADED), including the count from a byte accepted in the final LOAD cycle.
REQ-019 A download rise during HOLD restarts LOAD and aborts the countdown. A download rise during RUN re-enters LOAD and drops CORE_RESB the next cycle.
REQ-020 A byte accepted in the same cycle that IOCTL_DOWNLOAD falls is impossible by definition (REQ-010). A byte in the last high cycle is strobed normally.
REQ-021 Duplicate addresses are counted again. No address-coverage tracking is performed.

Reset
REQ-022 While RESB=0, the block SHALL hold:
  - ROMINIT_VALID=0, ROMINIT_SEL_*=0, ROMINIT_ADDR=0, ROMINIT_DATA=0;
  - counters=0, BOOT_LOADED=CHR_LOADED=LOAD_ERR=0;
  - CORE_RESB=0, state=IDLE.
REQ-023 On RESB release the block SHALL go IDLE -> HOLD next cycle, then RUN after 16 cycles, unless a download starts first. Reset mid-download discards the download; ROM contents are unchanged.

Structure
REQ-024 Package scv_pkg holds:
  - BOOT_BASE=0x0000, BOOT_SIZE=4096, CHR_BASE=0x1000, CHR_SIZE=1024;
  - HOLD_CYCLES=16;
  - the state enum typedef.
REQ-025 One sub-module, scv_rominit_region (saturating byte counter plus loaded flag), parameterised by size, is instantiated once per region.
REQ-026 scv_rominit_loader is instantiated in emu, replacing the combinational download logic and driving scv.RESB from CORE_RESB ANDed with ~reset.

Verification
REQ-027 Reset released, no download -> CORE_RESB rises exactly 17 cycles after RESB rises; no strobes.
REQ-028 Download of 5120 bytes at addr 0..0x13FF, one byte every 2 cycles, index 0:
  - 4096 boot strobes, then 1024 chr strobes with ADDR 0..0x3FF;
  - BOOT_LOADED=CHR_LOADED=1, LOAD_ERR=0;
  - CORE_RESB=1 17 cycles after DOWNLOAD falls.
REQ-029 Download of 3000 bytes at addr 0..2999 -> BOOT_LOADED=0, CHR_LOADED=0, LOAD_ERR=1 after the download ends.
REQ-030 Bytes at addr 0x1400 and 0x2000, and a byte with index=1 -> no strobe and counters unchanged.
REQ-031 Bytes on consecutive cycles at 0x0FFE, 0x0FFF, 0x1000 -> three consecutive strobes: boot 0xFFE, boot 0xFFF, chr 0x000.
REQ-032 RESB asserted at byte 100 of a download -> all outputs reach reset values asynchronously; after release, the HOLD -> RUN sequence occurs.

Source files
------------

// File: rtl/scv_pkg.sv
// scv_pkg: shared constants and types for the SCV ROM-init loader.
//   - region windows in the hps_io download address space
//   - HOLD_CYCLES: core-reset hold time after a download completes
//   - state_t: loader sequencing states
//   - rom_wr_t: one registered ROM write (select, address, data)
package scv_pkg;

  localparam int unsigned IOCTL_AW    = 25;
  localparam int unsigned BOOT_BASE   = 32'h0000;
  localparam int unsigned BOOT_SIZE   = 4096;
  localparam int unsigned CHR_BASE    = 32'h1000;
  localparam int unsigned CHR_SIZE    = 1024;
  localparam int unsigned HOLD_CYCLES = 16;
  localparam int unsigned HOLD_W      = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic        sel_boot;
    logic        sel_chr;
    logic [11:0] addr;
    logic [7:0]  data;
  } rom_wr_t;

  // Window test done as an unsigned offset compare: addresses below base
  // wrap to a huge offset, so one compare covers both bounds.
  function automatic logic in_window(input logic [IOCTL_AW-1:0] a,
                                     input int unsigned base,
                                     input int unsigned size);
    logic [IOCTL_AW-1:0] off;
    off = a - IOCTL_AW'(base);
    return off < IOCTL_AW'(size);
  endfunction

endpackage

// File: rtl/scv_rominit_region.sv
// scv_rominit_region: saturating byte counter with a "fully written" flag
// for one ROM region.
//   CLK, RESB : clock, async active-low reset
//   clr       : start of a new download; restarts the count
//   inc       : one byte strobed into this region
//   loaded    : count has reached SIZE (stays set until clr or reset)
module scv_rominit_region #(
  parameter int unsigned SIZE = 1024
) (
  input  logic CLK,
  input  logic RESB,
  input  logic clr,
  input  logic inc,
  output logic loaded
);

  localparam int unsigned CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(SIZE);

  logic [CW-1:0] cnt;

  // A byte arriving in the same cycle as clr is counted as the first byte
  // of the new download rather than being lost.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (clr) begin
      cnt    <= inc ? CW'(1) : '0;
      loaded <= inc && (FULL == CW'(1));
    end else if (inc && (cnt != FULL)) begin
      cnt    <= cnt + 1'b1;
      loaded <= ((cnt + 1'b1) == FULL);
    end
  end

endmodule

// File: rtl/scv_rominit_loader.sv
// scv_rominit_loader: turns hps_io download bytes (index 0) into one-cycle
// ROM write strobes for the SCV boot and character ROMs, tracks whether each
// region was fully written, and holds the core in reset during and shortly
// after a download.
//   CLK, RESB                     : clock, async active-low reset
//   IOCTL_DOWNLOAD/WR/INDEX/ADDR/DOUT : hps_io download interface
//   IOCTL_WAIT                    : backpressure, always 0
//   ROMINIT_SEL_BOOT/SEL_CHR/ADDR/DATA/VALID : registered ROM write port
//   CORE_RESB                     : active-low core reset (high only in RUN)
//   BOOT_LOADED/CHR_LOADED        : region completely written this download
//   LOAD_ERR                      : last download ended with a region short
module scv_rominit_loader
  import scv_pkg::*;
(
  input  logic                CLK,
  input  logic                RESB,
  input  logic                IOCTL_DOWNLOAD,
  input  logic                IOCTL_WR,
  input  logic [7:0]          IOCTL_INDEX,
  input  logic [IOCTL_AW-1:0] IOCTL_ADDR,
  input  logic [7:0]          IOCTL_DOUT,
  output logic                IOCTL_WAIT,
  output logic                ROMINIT_SEL_BOOT,
  output logic                ROMINIT_SEL_CHR,
  output logic [11:0]         ROMINIT_ADDR,
  output logic [7:0]          ROMINIT_DATA,
  output logic                ROMINIT_VALID,
  output logic                CORE_RESB,
  output logic                BOOT_LOADED,
  output logic                CHR_LOADED,
  output logic                LOAD_ERR
);

  logic              acc, hit_boot, hit_chr;
  logic              dl_q, dl_rise, dl_fall;
  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  rom_wr_t           wr_d, wr_q;
  logic              vld_q;

  assign IOCTL_WAIT = 1'b0;

  // ---------------- byte decode ----------------
  assign acc      = IOCTL_DOWNLOAD & IOCTL_WR & (IOCTL_INDEX == 8'd0);
  assign hit_boot = acc & in_window(IOCTL_ADDR, BOOT_BASE, BOOT_SIZE);
  assign hit_chr  = acc & in_window(IOCTL_ADDR, CHR_BASE, CHR_SIZE);

  always_comb begin
    wr_d          = '0;
    wr_d.sel_boot = hit_boot;
    wr_d.sel_chr  = hit_chr;
    wr_d.addr     = hit_boot ? IOCTL_ADDR[11:0] : {2'b00, IOCTL_ADDR[9:0]};
    wr_d.data     = IOCTL_DOUT;
  end

  // Strobe is a single-cycle pulse; select/address/data only load on a hit
  // so they keep the last written value between strobes.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      vld_q <= 1'b0;
      wr_q  <= '0;
    end else begin
      vld_q <= hit_boot | hit_chr;
      if (hit_boot | hit_chr) wr_q <= wr_d;
    end
  end

  assign ROMINIT_VALID    = vld_q;
  assign ROMINIT_SEL_BOOT = wr_q.sel_boot;
  assign ROMINIT_SEL_CHR  = wr_q.sel_chr;
  assign ROMINIT_ADDR     = wr_q.addr;
  assign ROMINIT_DATA     = wr_q.data;

  // ---------------- region tracking ----------------
  assign dl_rise = IOCTL_DOWNLOAD & ~dl_q & (IOCTL_INDEX == 8'd0);
  assign dl_fall = ~IOCTL_DOWNLOAD & dl_q;

  scv_rominit_region #(.SIZE(BOOT_SIZE)) u_boot (
    .CLK    (CLK),
    .RESB   (RESB),
    .clr    (dl_rise),
    .inc    (hit_boot),
    .loaded (BOOT_LOADED)
  );

  scv_rominit_region #(.SIZE(CHR_SIZE)) u_chr (
    .CLK    (CLK),
    .RESB   (RESB),
    .clr    (dl_rise),
    .inc    (hit_chr),
    .loaded (CHR_LOADED)
  );

  // ---------------- sequencing ----------------
  // Region counters update on the same edge that registers the strobe, so
  // when the download falls the loaded flags already include the byte from
  // the final high cycle.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      dl_q      <= 1'b0;
      CORE_RESB <= 1'b0;
      LOAD_ERR  <= 1'b0;
    end else begin
      dl_q <= IOCTL_DOWNLOAD;
      if (dl_rise) begin
        // A new download wins from any state, aborting any HOLD countdown.
        state     <= ST_LOAD;
        CORE_RESB <= 1'b0;
        LOAD_ERR  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
          ST_LOAD: begin
            if (dl_fall) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
              LOAD_ERR <= ~(BOOT_LOADED & CHR_LOADED);
            end
          end
          ST_HOLD: begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
              state     <= ST_RUN;
              CORE_RESB <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_RUN: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scv_rominit_loader.sv
// Bench for scv_rominit_loader: randomized data/gaps driven into the hps_io
// side; a queue-based model of expected strobes plus plain byte counts per
// region predicts the ROM write port and loaded/error flags.
module tb_scv_rominit_loader;

  logic        CLK = 1'b0;
  logic        RESB;
  logic        IOCTL_DOWNLOAD, IOCTL_WR;
  logic [7:0]  IOCTL_INDEX;
  logic [24:0] IOCTL_ADDR;
  logic [7:0]  IOCTL_DOUT;
  logic        IOCTL_WAIT, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_VALID;
  logic [11:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        CORE_RESB, BOOT_LOADED, CHR_LOADED, LOAD_ERR;

  int checks = 0;
  int errors = 0;

  localparam int RUN_DELAY = 17;   // edges from release/fall to CORE_RESB high

  typedef struct {
    bit boot;
    bit chr;
    int addr;
    int data;
  } exp_t;

  exp_t q[$];
  exp_t last;
  exp_t mon_e;
  int   boot_n = 0;
  int   chr_n  = 0;

  always #5 CLK = ~CLK;

  scv_rominit_loader dut (
    .CLK              (CLK),
    .RESB             (RESB),
    .IOCTL_DOWNLOAD   (IOCTL_DOWNLOAD),
    .IOCTL_WR         (IOCTL_WR),
    .IOCTL_INDEX      (IOCTL_INDEX),
    .IOCTL_ADDR       (IOCTL_ADDR),
    .IOCTL_DOUT       (IOCTL_DOUT),
    .IOCTL_WAIT       (IOCTL_WAIT),
    .ROMINIT_SEL_BOOT (ROMINIT_SEL_BOOT),
    .ROMINIT_SEL_CHR  (ROMINIT_SEL_CHR),
    .ROMINIT_ADDR     (ROMINIT_ADDR),
    .ROMINIT_DATA     (ROMINIT_DATA),
    .ROMINIT_VALID    (ROMINIT_VALID),
    .CORE_RESB        (CORE_RESB),
    .BOOT_LOADED      (BOOT_LOADED),
    .CHR_LOADED       (CHR_LOADED),
    .LOAD_ERR         (LOAD_ERR)
  );

  // Strobe monitor: every strobe must match the oldest expected write; in
  // non-strobe cycles the port must still show the last write.
  always @(negedge CLK) begin
    if (RESB === 1'b1) begin
      checks++;
      if (ROMINIT_VALID === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected addr=%h boot=%b chr=%b", ROMINIT_ADDR, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR);
        end else begin
          mon_e = q.pop_front();
          if ({ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA} !==
              {mon_e.boot, mon_e.chr, 12'(mon_e.addr), 8'(mon_e.data)}) begin
            errors++;
            $display("FAIL strobe_fields got b=%b c=%b a=%h d=%h exp b=%b c=%b a=%h d=%h",
                     ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA,
                     mon_e.boot, mon_e.chr, 12'(mon_e.addr), 8'(mon_e.data));
          end
          last = mon_e;
        end
      end else if ({ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA} !==
                   {last.boot, last.chr, 12'(last.addr), 8'(last.data)}) begin
        errors++;
        $display("FAIL hold_fields got a=%h d=%h exp a=%h d=%h valid=%b",
                 ROMINIT_ADDR, ROMINIT_DATA, 12'(last.addr), 8'(last.data), ROMINIT_VALID);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive one byte for one cycle; the model decides from the address map
  // whether a strobe is expected and bumps the saturating region counts.
  task automatic put_byte(input logic [7:0] idx, input int addr, input logic [7:0] d);
    exp_t e;
    IOCTL_WR    = 1'b1;
    IOCTL_INDEX = idx;
    IOCTL_ADDR  = 25'(addr);
    IOCTL_DOUT  = d;
    if (IOCTL_DOWNLOAD && idx == 8'd0 && addr < 'h1400) begin
      e.boot = (addr < 'h1000);
      e.chr  = !e.boot;
      e.addr = e.boot ? addr : addr - 'h1000;
      e.data = int'(d);
      q.push_back(e);
      if (e.boot) begin
        if (boot_n < 4096) boot_n++;
      end else if (chr_n < 1024) chr_n++;
    end
    @(posedge CLK);
    #1;
    IOCTL_WR    = 1'b0;
    IOCTL_INDEX = 8'd0;
  endtask

  task automatic dl_start();
    IOCTL_INDEX    = 8'd0;
    IOCTL_DOWNLOAD = 1'b1;
    boot_n = 0;
    chr_n  = 0;
    tick(1);
  endtask

  task automatic wait_run(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge CLK);
      #1;
      if (CORE_RESB === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    RESB = 1'b1; IOCTL_DOWNLOAD = 0; IOCTL_WR = 0; IOCTL_INDEX = 0; IOCTL_ADDR = 0; IOCTL_DOUT = 0;
    last = '{0, 0, 0, 0};
    #2 RESB = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA} !== 23'd0) begin
      errors++; $display("FAIL reset_rom_port got %b exp 0", {ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA});
    end
    checks++;
    if ({CORE_RESB, BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {CORE_RESB, BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
    checks++;
    if (IOCTL_WAIT !== 1'b0) begin errors++; $display("FAIL ioctl_wait got %b exp 0", IOCTL_WAIT); end
    RESB = 1'b1;
    wait_run(n);
    checks++;
    if (n != RUN_DELAY) begin errors++; $display("FAIL reset_run_delay got %0d exp %0d", n, RUN_DELAY); end
  endtask

  task automatic test_full_load();
    int n;
    dl_start();
    checks++;
    if (CORE_RESB !== 1'b0) begin errors++; $display("FAIL full_core_resb_load got %b exp 0", CORE_RESB); end
    for (int i = 0; i < 5120; i++) begin
      put_byte(8'd0, i, 8'($urandom));
      checks++;
      if (BOOT_LOADED !== (boot_n == 4096) || CHR_LOADED !== (chr_n == 1024)) begin
        errors++; $display("FAIL full_loaded_i%0d got %b%b exp %b%b", i, BOOT_LOADED, CHR_LOADED, boot_n == 4096, chr_n == 1024);
      end
      tick(1);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL full_missing_strobes got %0d pending exp 0", q.size()); end
    IOCTL_DOWNLOAD = 1'b0;
    wait_run(n);
    checks++;
    if (n != RUN_DELAY) begin errors++; $display("FAIL full_run_delay got %0d exp %0d", n, RUN_DELAY); end
    checks++;
    if ({BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== {boot_n == 4096, chr_n == 1024, !(boot_n == 4096 && chr_n == 1024)}) begin
      errors++; $display("FAIL full_flags got %b exp 110", {BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
  endtask

  task automatic test_partial();
    int n;
    dl_start();
    checks++;
    if ({BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== 3'b000) begin
      errors++; $display("FAIL partial_clear got %b exp 000", {BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
    for (int i = 0; i < 3000; i++) begin
      put_byte(8'd0, i, 8'($urandom));
      tick($urandom_range(0, 2));
    end
    tick(1);
    IOCTL_DOWNLOAD = 1'b0;
    wait_run(n);
    checks++;
    if (n != RUN_DELAY) begin errors++; $display("FAIL partial_run_delay got %0d exp %0d", n, RUN_DELAY); end
    checks++;
    if ({BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== {boot_n == 4096, chr_n == 1024, !(boot_n == 4096 && chr_n == 1024)}) begin
      errors++; $display("FAIL partial_flags got %b exp 001", {BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
  endtask

  task automatic test_discard_boundary();
    int n;
    logic [7:0] d [3];
    int a [3];
    dl_start();
    checks++;
    if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL discard_err_clear got %b exp 0", LOAD_ERR); end
    for (int i = 0; i < 4095; i++) put_byte(8'd0, i, 8'($urandom));
    for (int i = 'h1000; i < 'h13FF; i++) put_byte(8'd0, i, 8'($urandom));
    tick(1);
    // Out-of-range and wrong-index bytes: each would complete a region if counted.
    put_byte(8'd0, 'h1400, 8'hA5);
    checks++;
    if (ROMINIT_VALID !== 1'b0) begin errors++; $display("FAIL discard_1400 valid got %b exp 0", ROMINIT_VALID); end
    tick(1);
    put_byte(8'd0, 'h2000, 8'h5A);
    checks++;
    if (ROMINIT_VALID !== 1'b0) begin errors++; $display("FAIL discard_2000 valid got %b exp 0", ROMINIT_VALID); end
    tick(1);
    put_byte(8'd1, 'h0005, 8'h3C);
    checks++;
    if (ROMINIT_VALID !== 1'b0) begin errors++; $display("FAIL discard_index1 valid got %b exp 0", ROMINIT_VALID); end
    tick(2);
    checks++;
    if ({BOOT_LOADED, CHR_LOADED} !== {boot_n == 4096, chr_n == 1024}) begin
      errors++; $display("FAIL discard_counts got %b%b exp %b%b", BOOT_LOADED, CHR_LOADED, boot_n == 4096, chr_n == 1024);
    end
    // Back-to-back across the boot/chr boundary (0xFFE is a duplicate).
    a[0] = 'h0FFE; a[1] = 'h0FFF; a[2] = 'h1000;
    for (int k = 0; k < 3; k++) d[k] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      put_byte(8'd0, a[k], d[k]);
      checks++;
      if ({ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA} !==
          {1'b1, k < 2, k == 2, (k < 2) ? 12'(a[k]) : 12'(a[k] - 'h1000), d[k]}) begin
        errors++; $display("FAIL b2b_strobe%0d got v=%b b=%b c=%b a=%h d=%h", k, ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA);
      end
      checks++;
      if ({BOOT_LOADED, CHR_LOADED} !== {boot_n == 4096, chr_n == 1024}) begin
        errors++; $display("FAIL b2b_loaded%0d got %b%b exp %b%b", k, BOOT_LOADED, CHR_LOADED, boot_n == 4096, chr_n == 1024);
      end
    end
    IOCTL_DOWNLOAD = 1'b0;
    wait_run(n);
    checks++;
    if (n != RUN_DELAY) begin errors++; $display("FAIL b2b_run_delay got %0d exp %0d", n, RUN_DELAY); end
    checks++;
    if (LOAD_ERR !== !(boot_n == 4096 && chr_n == 1024)) begin
      errors++; $display("FAIL b2b_load_err got %b exp 0", LOAD_ERR);
    end
  endtask

  task automatic test_hold_abort_rerun();
    int n;
    // From RUN: a new download drops the core reset on the next edge.
    dl_start();
    checks++;
    if ({CORE_RESB, LOAD_ERR} !== 2'b00) begin errors++; $display("FAIL rerun_enter got %b exp 00", {CORE_RESB, LOAD_ERR}); end
    tick(3);
    IOCTL_DOWNLOAD = 1'b0;
    tick(5);
    // In HOLD now; restart before the countdown ends and stay in LOAD.
    dl_start();
    tick(20);
    checks++;
    if (CORE_RESB !== 1'b0) begin errors++; $display("FAIL hold_abort core_resb got %b exp 0", CORE_RESB); end
    IOCTL_DOWNLOAD = 1'b0;
    wait_run(n);
    checks++;
    if (n != RUN_DELAY) begin errors++; $display("FAIL hold_abort_run_delay got %0d exp %0d", n, RUN_DELAY); end
    checks++;
    if ({BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== 3'b001) begin
      errors++; $display("FAIL empty_dl_flags got %b exp 001", {BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    dl_start();
    for (int i = 0; i < 100; i++) begin
      if (i != 0) tick($urandom_range(0, 1));
      put_byte(8'd0, $urandom_range(0, 'h13FF), 8'($urandom));
    end
    checks++;
    if (ROMINIT_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", ROMINIT_VALID); end
    #2 RESB = 1'b0;
    #1;
    checks++;
    if ({ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA,
         CORE_RESB, BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== 27'd0) begin
      errors++; $display("FAIL mid_async_reset got %b exp 0", {ROMINIT_VALID, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_ADDR, ROMINIT_DATA, CORE_RESB, BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
    q.delete();
    last = '{0, 0, 0, 0};
    boot_n = 0;
    chr_n  = 0;
    IOCTL_DOWNLOAD = 1'b0;
    IOCTL_WR       = 1'b0;
    tick(3);
    RESB = 1'b1;
    wait_run(n);
    checks++;
    if (n != RUN_DELAY) begin errors++; $display("FAIL mid_run_delay got %0d exp %0d", n, RUN_DELAY); end
    checks++;
    if ({BOOT_LOADED, CHR_LOADED, LOAD_ERR} !== 3'b000) begin
      errors++; $display("FAIL mid_flags got %b exp 000", {BOOT_LOADED, CHR_LOADED, LOAD_ERR});
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_partial();
    test_discard_boundary();
    test_hold_abort_rerun();
    test_reset_mid();
    tick(3);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL final_pending got %0d exp 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
